mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
- Sits directly downstream of the MEM stage's byte-enable/data-extend logic.
- Consumes the MEM stage's address, byte enables and aligned store data.
- Routes each access to the on-chip data RAM or to the peripheral bus (timer/UART) by address.
- Returns raw read data to the data extender, and stalls the pipeline while an access is outstanding.

Parameters:
DM_LIMIT, 32'h0000_2FFF, last byte address of data RAM (base 0)
PER_BASE, 32'h0000_7F00, first peripheral byte address
PER_LIMIT, 32'h0000_7F3F, last peripheral byte address
TIMEOUT, 16, max cycles waiting for per_ack before bus error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  32  byte address from MEM stage
byteEn  in  4  store byte enables from MEM stage; nonzero = store
memWD  in  32  lane-aligned store data
rdReq  in  1  load request (mutually exclusive with nonzero byteEn)
memRD_orig  out  32  raw word to data extender
stall  out  1  freeze pipeline this cycle
busErr  out  1  one-cycle error pulse
dm_addr  out  32  RAM word address (addr[31:2] with 2'b00 appended)
dm_we  out  4  RAM byte write enables
dm_wd  out  32  RAM write data
dm_rd  in  32  RAM read data, valid one cycle after dm_addr
per_addr  out  32  peripheral address
per_we  out  1  peripheral write
per_wd  out  32  peripheral write data
per_req  out  1  peripheral request, held until ack
per_ack  in  1  peripheral completion, single-cycle
per_rd  in  32  peripheral read data, valid with per_ack

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0: stall, busErr, per_req, per_we, dm_we, memRD_orig register, timeout counter.
  - Reset mid-access aborts it; per_req is low after that edge; no busErr.
- Requests:
  - Sampled only in IDLE.
  - Upstream holds addr/byteEn/memWD/rdReq stable while stall=1.
- Decode:
  - DM: addr <= DM_LIMIT.
  - PER: PER_BASE <= addr <= PER_LIMIT.
  - Anything else: ERR.
- Routing:
  - dm_addr, dm_wd and per_addr, per_wd are combinational from inputs.
  - dm_we = byteEn when decode is DM and state is IDLE, else 0.
- States:
  - IDLE:
    - No request: stall=0.
    - DM store: RAM written this cycle; stall=0; stay IDLE (zero-wait store).
    - DM load: stall=1 → DM_RD.
    - PER access with byteEn in {0000, 1111}: per_req=1 registered next edge, per_we=(byteEn!=0), stall=1 → PER_WAIT; counter cleared.
    - PER store with partial byteEn: no access; busErr=1 next cycle → DONE with rdata 0.
    - ERR decode with any request: busErr=1 next cycle → DONE with rdata 0.
  - DM_RD:
    - memRD_orig = dm_rd (combinational pass-through).
    - stall=0 → IDLE.
    - Total load latency is 2 cycles.
  - PER_WAIT:
    - stall=1, per_req=1; counter increments each cycle.
    - per_ack: capture per_rd into rdata, drop per_req next edge → DONE.
    - Counter reaches TIMEOUT without ack: drop per_req, busErr pulse, rdata=0 → DONE.
    - per_ack on the same cycle as timeout: the ack wins.
  - DONE:
    - memRD_orig = rdata; stall=0 → IDLE.
    - The pipeline advances past the held request this cycle, so it is never re-issued.
- Outside DM_RD/DONE, memRD_orig holds its last value.
- busErr is high for exactly one cycle per failed access, coincident with the DONE entry cycle.
- per_ack arriving in IDLE, DM_RD or DONE is ignored.
- byteEn != 0 together with rdReq=1 is treated as a store.

Test Plan:
- DM store then load:
  - Store addr=0x10, byteEn=0011, memWD=0x0000BEEF → dm_we=0011 same cycle, stall=0.
  - Load addr=0x10 → stall high 1 cycle, then memRD_orig=RAM word with low half 0xBEEF.
- PER read with 3-cycle ack:
  - rdReq at addr=0x7F04; per_ack on 3rd PER_WAIT cycle with per_rd=0x12345678.
  - stall high 4 cycles total; DONE shows 0x12345678; per_req low afterward.
- PER timeout, TIMEOUT=16:
  - Load addr=0x7F08, per_ack never asserted.
  - per_req drops after 16 cycles; busErr 1-cycle pulse; memRD_orig=0; stall releases next cycle.
- Illegal accesses:
  - Load addr=0x5000 → busErr pulse, no dm_we, no per_req.
  - PER store byteEn=0001 at 0x7F00 → busErr, no per_req.
- Reset mid PER_WAIT:
  - Assert reset on 2nd wait cycle → per_req=0, stall=0, busErr=0 after edge.
  - A late per_ack is ignored.
- Back-to-back:
  - DM store, DM load, PER write (ack 1 cycle), DM load on consecutive requests.
  - Each completes exactly once; no duplicate RAM write or per_req.

Source files
------------

// File: rtl/mem_bridge_if.sv
// Bus bundle between the MEM stage, the data RAM and the peripheral bus.
// The bridge uses the slave view; whatever drives the pipeline/RAM/peripherals uses master.
interface mem_bridge_if;
  logic [31:0] addr;
  logic [3:0]  byteEn;
  logic [31:0] memWD;
  logic        rdReq;
  logic [31:0] memRD_orig;
  logic        stall;
  logic        busErr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;
  logic [31:0] per_addr;
  logic        per_we;
  logic [31:0] per_wd;
  logic        per_req;
  logic        per_ack;
  logic [31:0] per_rd;

  modport slave (
    input  addr, byteEn, memWD, rdReq, dm_rd, per_ack, per_rd,
    output memRD_orig, stall, busErr, dm_addr, dm_we, dm_wd,
           per_addr, per_we, per_wd, per_req
  );

  modport master (
    output addr, byteEn, memWD, rdReq, dm_rd, per_ack, per_rd,
    input  memRD_orig, stall, busErr, dm_addr, dm_we, dm_wd,
           per_addr, per_we, per_wd, per_req
  );
endinterface

// File: rtl/mem_bridge.sv
// Routes MEM-stage accesses to data RAM or the peripheral bus and stalls while one is outstanding.
//   state    | meaning
//   IDLE     | sample request; DM stores complete here with no wait
//   DM_RD    | RAM read data valid, passed straight to memRD_orig
//   PER_WAIT | per_req held, counting cycles toward bus-error timeout
//   DONE     | present captured peripheral data (or 0 on error), release stall
module mem_bridge #(
  parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
  parameter logic [31:0] PER_BASE  = 32'h0000_7F00,
  parameter logic [31:0] PER_LIMIT = 32'h0000_7F3F,
  parameter int          TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_bridge_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DM_RD, PER_WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rd_hold;
  logic          per_req_q;
  logic          per_we_q;
  logic          bus_err_q;

  logic is_store, is_req, in_dm, in_per, be_full;

  assign is_store = |bus.byteEn;
  assign is_req   = is_store | bus.rdReq;
  assign in_dm    = bus.addr <= DM_LIMIT;
  assign in_per   = (bus.addr >= PER_BASE) && (bus.addr <= PER_LIMIT);
  assign be_full  = (bus.byteEn == 4'b0000) || (bus.byteEn == 4'b1111);

  assign bus.dm_addr  = {bus.addr[31:2], 2'b00};
  assign bus.dm_wd    = bus.memWD;
  assign bus.dm_we    = (state == IDLE && in_dm) ? bus.byteEn : 4'b0000;
  assign bus.per_addr = bus.addr;
  assign bus.per_wd   = bus.memWD;
  assign bus.per_req  = per_req_q;
  assign bus.per_we   = per_we_q;
  assign bus.busErr   = bus_err_q;

  // RAM data bypasses the holding register so a load costs only two cycles.
  assign bus.memRD_orig = (state == DM_RD) ? bus.dm_rd : rd_hold;

  always_comb begin
    bus.stall = 1'b0;
    case (state)
      IDLE:     bus.stall = is_req && !(in_dm && is_store);
      PER_WAIT: bus.stall = 1'b1;
      default:  bus.stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_hold   <= '0;
      per_req_q <= 1'b0;
      per_we_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (is_req) begin
            if (in_dm) begin
              if (!is_store) state <= DM_RD;
            end else if (in_per && be_full) begin
              per_req_q <= 1'b1;
              per_we_q  <= is_store;
              cnt       <= '0;
              state     <= PER_WAIT;
            end else begin
              bus_err_q <= 1'b1;
              rd_hold   <= '0;
              state     <= DONE;
            end
          end
        end
        DM_RD: begin
          rd_hold <= bus.dm_rd;
          state   <= IDLE;
        end
        PER_WAIT: begin
          // An ack in the final counted cycle still completes normally.
          if (bus.per_ack) begin
            rd_hold   <= bus.per_rd;
            per_req_q <= 1'b0;
            per_we_q  <= 1'b0;
            state     <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rd_hold   <= '0;
            per_req_q <= 1'b0;
            per_we_q  <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized bench for mem_bridge: bench-side RAM and peripheral responder,
// expectations from a transaction-level model of the routing and timing rules.
module tb_mem_bridge;
  localparam logic [31:0] DM_LIMIT  = 32'h0000_2FFF;
  localparam logic [31:0] PER_BASE  = 32'h0000_7F00;
  localparam logic [31:0] PER_LIMIT = 32'h0000_7F3F;
  localparam int          TIMEOUT   = 16;
  localparam int          WORDS     = 3072;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_bridge_if bus();

  mem_bridge #(
    .DM_LIMIT(DM_LIMIT), .PER_BASE(PER_BASE), .PER_LIMIT(PER_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_n;
    int          err_n;
    int          we_n;
    logic [3:0]  we_val;
    int          preq_n;
    logic [31:0] data;
    bit          chk_data;
    bit          pwe_ok;
    bit          done;
  } obs_t;

  logic [31:0] ram [0:WORDS-1];
  logic [31:0] mdl [0:WORDS-1];
  logic [11:0] widx;

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h0001_0103) ^ 32'hA5A5_5A5A;
  endfunction

  assign widx = bus.dm_addr[13:2];

  // Synchronous data RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= seed(i);
    end else if (widx < 12'(WORDS)) begin
      for (int b = 0; b < 4; b++)
        if (bus.dm_we[b]) ram[widx][8*b +: 8] <= bus.dm_wd[8*b +: 8];
    end
    bus.dm_rd <= (widx < 12'(WORDS)) ? ram[widx] : 32'h0;
  end

  task automatic init_model();
    for (int i = 0; i < WORDS; i++) mdl[i] = seed(i);
  endtask

  task automatic set_idle();
    bus.addr = 32'h0; bus.byteEn = 4'h0; bus.memWD = 32'h0; bus.rdReq = 1'b0;
    bus.per_ack = 1'b0; bus.per_rd = 32'h0;
  endtask

  // Issues one request and plays the peripheral, acking on the k-th per_req cycle (k=0: never).
  task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input logic rd, input int k, input logic [31:0] pd, output obs_t o);
    o = '{default: 0};
    o.pwe_ok = 1'b1;
    @(negedge clk);
    bus.addr = a; bus.byteEn = be; bus.memWD = wd; bus.rdReq = rd; bus.per_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.dm_we != 4'h0) begin o.we_n++; o.we_val = bus.dm_we; end
      if (bus.busErr) o.err_n++;
      if (bus.per_req) begin
        o.preq_n++;
        if (bus.per_we !== (be != 4'h0)) o.pwe_ok = 1'b0;
      end
      if (!bus.stall) begin
        o.data = bus.memRD_orig;
        o.done = 1'b1;
        break;
      end
      o.stall_n++;
      bus.per_ack = bus.per_req && (o.preq_n == k);
      bus.per_rd  = pd;
      @(negedge clk);
    end
    bus.per_ack = 1'b0;
  endtask

  // Transaction-level expectation; also applies DM stores to the model RAM.
  task automatic predict(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input logic rd, input int k, input logic [31:0] pd, output obs_t e);
    logic [11:0] idx;
    e = '{default: 0};
    e.pwe_ok = 1'b1;
    e.done   = 1'b1;
    idx = a[13:2];
    if (a <= DM_LIMIT) begin
      if (be != 4'h0) begin
        e.we_n = 1; e.we_val = be;
        for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end else if (rd) begin
        e.stall_n = 1; e.data = mdl[idx]; e.chk_data = 1'b1;
      end
    end else if (a >= PER_BASE && a <= PER_LIMIT && (be == 4'h0 || be == 4'hF)) begin
      e.chk_data = 1'b1;
      if (k >= 1 && k <= TIMEOUT) begin
        e.stall_n = 1 + k; e.preq_n = k; e.data = pd;
      end else begin
        e.stall_n = 1 + TIMEOUT; e.preq_n = TIMEOUT; e.err_n = 1; e.data = 32'h0;
      end
    end else begin
      e.stall_n = 1; e.err_n = 1; e.data = 32'h0; e.chk_data = 1'b1;
    end
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.stall, bus.busErr, bus.per_req, bus.per_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: stall/busErr/per_req/per_we got %b expected 0000",
               {bus.stall, bus.busErr, bus.per_req, bus.per_we});
    end
    n_checks++;
    if (bus.dm_we !== 4'h0) begin n_fail++; $display("FAIL reset_dm_we: got %b expected 0000", bus.dm_we); end
    n_checks++;
    if (bus.memRD_orig !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.memRD_orig); end
    @(negedge clk);
    reset = 1'b0;
    init_model();
  endtask

  task automatic test_dm_store_load();
    obs_t o, e;
    predict(32'h10, 4'b0011, 32'h0000_BEEF, 1'b0, 0, 32'h0, e);
    access(32'h10, 4'b0011, 32'h0000_BEEF, 1'b0, 0, 32'h0, o);
    n_checks++;
    if (o.we_n !== 1 || o.we_val !== 4'b0011) begin
      n_fail++; $display("FAIL dm_store_we: got %0d x %b expected 1 x 0011", o.we_n, o.we_val);
    end
    n_checks++;
    if (o.stall_n !== 0) begin n_fail++; $display("FAIL dm_store_stall: got %0d expected 0", o.stall_n); end
    predict(32'h10, 4'b0000, 32'h0, 1'b1, 0, 32'h0, e);
    access(32'h10, 4'b0000, 32'h0, 1'b1, 0, 32'h0, o);
    n_checks++;
    if (o.stall_n !== 1) begin n_fail++; $display("FAIL dm_load_stall: got %0d expected 1", o.stall_n); end
    n_checks++;
    if (o.data[15:0] !== 16'hBEEF || o.data !== e.data) begin
      n_fail++; $display("FAIL dm_load_data: got %h expected %h", o.data, e.data);
    end
  endtask

  task automatic test_per_read();
    obs_t o;
    access(32'h7F04, 4'h0, 32'h0, 1'b1, 3, 32'h1234_5678, o);
    n_checks++;
    if (o.stall_n !== 4) begin n_fail++; $display("FAIL per_read_stall: got %0d expected 4", o.stall_n); end
    n_checks++;
    if (o.data !== 32'h1234_5678) begin n_fail++; $display("FAIL per_read_data: got %h expected 12345678", o.data); end
    n_checks++;
    if (o.preq_n !== 3 || o.pwe_ok !== 1'b1) begin
      n_fail++; $display("FAIL per_read_req: per_req cycles %0d expected 3, per_we ok %0b", o.preq_n, o.pwe_ok);
    end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (bus.per_req !== 1'b0 || bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL per_read_after: per_req %b stall %b expected 0 0", bus.per_req, bus.stall);
    end
  endtask

  task automatic test_per_timeout();
    obs_t o;
    access(32'h7F08, 4'h0, 32'h0, 1'b1, 0, 32'hFFFF_FFFF, o);
    n_checks++;
    if (o.preq_n !== TIMEOUT) begin n_fail++; $display("FAIL timeout_req: got %0d expected %0d", o.preq_n, TIMEOUT); end
    n_checks++;
    if (o.err_n !== 1) begin n_fail++; $display("FAIL timeout_buserr: got %0d pulses expected 1", o.err_n); end
    n_checks++;
    if (o.data !== 32'h0 || o.stall_n !== TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_done: data %h stall %0d expected 0 and %0d", o.data, o.stall_n, TIMEOUT + 1);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    access(32'h5000, 4'h0, 32'h0, 1'b1, 1, 32'h1111_1111, o);
    n_checks++;
    if (o.err_n !== 1 || o.we_n !== 0 || o.preq_n !== 0) begin
      n_fail++; $display("FAIL illegal_load: busErr %0d dm_we %0d per_req %0d expected 1 0 0", o.err_n, o.we_n, o.preq_n);
    end
    n_checks++;
    if (o.data !== 32'h0 || o.stall_n !== 1) begin
      n_fail++; $display("FAIL illegal_load_done: data %h stall %0d expected 0 and 1", o.data, o.stall_n);
    end
    access(32'h7F00, 4'b0001, 32'h0000_00AA, 1'b0, 1, 32'h2222_2222, o);
    n_checks++;
    if (o.err_n !== 1 || o.preq_n !== 0 || o.we_n !== 0) begin
      n_fail++; $display("FAIL partial_per_store: busErr %0d per_req %0d dm_we %0d expected 1 0 0", o.err_n, o.preq_n, o.we_n);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    bus.addr = 32'h7F0C; bus.byteEn = 4'h0; bus.rdReq = 1'b1; bus.per_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      if (bus.per_req) seen++;
    end
    n_checks++;
    if (seen !== 2) begin n_fail++; $display("FAIL reset_mid_pre: per_req cycles %0d expected 2", seen); end
    reset = 1'b1;
    set_idle();
    @(negedge clk); #1;
    n_checks++;
    if ({bus.per_req, bus.stall, bus.busErr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_abort: per_req/stall/busErr got %b expected 000", {bus.per_req, bus.stall, bus.busErr});
    end
    reset = 1'b0;
    bus.per_ack = 1'b1; bus.per_rd = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    bus.per_ack = 1'b0;
    n_checks++;
    if ({bus.per_req, bus.stall, bus.busErr} !== 3'b000 || bus.memRD_orig !== 32'h0) begin
      n_fail++; $display("FAIL late_ack: per_req/stall/busErr %b rdata %h expected 000 and 0",
                         {bus.per_req, bus.stall, bus.busErr}, bus.memRD_orig);
    end
    init_model();
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa [4]  = '{32'h20, 32'h20, 32'h7F10, 32'h20};
    logic [3:0]  qbe [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic        qrd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    obs_t o, e;
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      predict(qa[i], qbe[i], wd, qrd[i], 1, 32'h0BAD_F00D, e);
      access(qa[i], qbe[i], wd, qrd[i], 1, 32'h0BAD_F00D, o);
      n_checks++;
      if (o.done !== e.done) begin n_fail++; $display("FAIL b2b_%0d_hang: stall never released", i); end
      n_checks++;
      if (o.stall_n !== e.stall_n) begin n_fail++; $display("FAIL b2b_%0d_stall: got %0d expected %0d", i, o.stall_n, e.stall_n); end
      n_checks++;
      if (o.we_n !== e.we_n || o.preq_n !== e.preq_n) begin
        n_fail++; $display("FAIL b2b_%0d_issue: dm_we %0d per_req %0d expected %0d %0d", i, o.we_n, o.preq_n, e.we_n, e.preq_n);
      end
      n_checks++;
      if (o.err_n !== e.err_n) begin n_fail++; $display("FAIL b2b_%0d_buserr: got %0d expected %0d", i, o.err_n, e.err_n); end
      if (e.chk_data) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("FAIL b2b_%0d_data: got %h expected %h", i, o.data, e.data); end
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [31:0] a, wd, pd;
    logic [3:0]  be;
    logic        rd;
    int          k, sel;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      wd  = $urandom;
      pd  = $urandom;
      k   = int'($urandom_range(1, 6));
      if ($urandom_range(0, 4) == 0) k = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
      if (sel < 4) begin
        a = $urandom_range(0, DM_LIMIT);
        if ($urandom_range(0, 1) == 1) begin
          be = 4'($urandom_range(1, 15)); rd = 1'($urandom_range(0, 1));
        end else begin
          be = 4'h0; rd = 1'b1;
        end
      end else if (sel < 8) begin
        a = PER_BASE + $urandom_range(0, 63);
        case ($urandom_range(0, 5))
          0:       begin be = 4'($urandom_range(1, 14)); rd = 1'b0; end
          1, 2:    begin be = 4'hF; rd = 1'($urandom_range(0, 1)); end
          default: begin be = 4'h0; rd = 1'b1; end
        endcase
      end else begin
        a  = ($urandom_range(0, 1) == 1) ? $urandom_range(DM_LIMIT + 1, PER_BASE - 1)
                                         : $urandom_range(PER_LIMIT + 1, 32'hFFFF_FFFF);
        be = 4'($urandom_range(0, 15));
        rd = (be == 4'h0);
      end
      predict(a, be, wd, rd, k, pd, e);
      access(a, be, wd, rd, k, pd, o);
      n_checks++;
      if (o.done !== e.done) begin n_fail++; $display("FAIL rnd_%0d_hang: stall never released addr %h", i, a); end
      n_checks++;
      if (o.stall_n !== e.stall_n) begin
        n_fail++; $display("FAIL rnd_%0d_stall: got %0d expected %0d addr %h be %b k %0d", i, o.stall_n, e.stall_n, a, be, k);
      end
      n_checks++;
      if (o.err_n !== e.err_n) begin n_fail++; $display("FAIL rnd_%0d_buserr: got %0d expected %0d addr %h", i, o.err_n, e.err_n, a); end
      n_checks++;
      if (o.we_n !== e.we_n || o.we_val !== e.we_val) begin
        n_fail++; $display("FAIL rnd_%0d_dm_we: got %0d x %b expected %0d x %b", i, o.we_n, o.we_val, e.we_n, e.we_val);
      end
      n_checks++;
      if (o.preq_n !== e.preq_n || o.pwe_ok !== e.pwe_ok) begin
        n_fail++; $display("FAIL rnd_%0d_per_req: cycles %0d we_ok %0b expected %0d 1", i, o.preq_n, o.pwe_ok, e.preq_n);
      end
      if (e.chk_data) begin
        n_checks++;
        if (o.data !== e.data) begin n_fail++; $display("FAIL rnd_%0d_data: got %h expected %h addr %h", i, o.data, e.data, a); end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); set_idle(); #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.busErr !== 1'b0) begin
          n_fail++; $display("FAIL rnd_%0d_idle: stall %b busErr %b expected 0 0", i, bus.stall, bus.busErr);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_dm_store_load();
    test_per_read();
    test_per_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
